// File: rtl/sm4_cmd_ctrl.sv
// Command sequencer for the SM4 core: orders key expansion and data handshakes,
// caches the last expanded key/mode, and returns results or timeout errors.
module sm4_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [127:0] cmd_key_i,
    input  logic [127:0] cmd_data_i,
    input  logic         cmd_mode_i,
    input  logic         key_flush_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [127:0] rsp_data_o,
    output logic         rsp_err_o,
    output logic         core_sm4_enable_o,
    output logic         core_key_exp_en_o,
    output logic         core_key_valid_o,
    output logic [127:0] core_key_o,
    output logic         core_encdec_en_o,
    output logic         core_encdec_sel_o,
    output logic         core_valid_o,
    output logic [127:0] core_data_o,
    input  logic         core_ready_i,
    input  logic         core_key_ready_i,
    input  logic [127:0] core_result_i,
    output logic         busy_o
);

    typedef enum logic [2:0] {
        StIdle, StKeyRst, StKeyLoad, StKeyWait, StIssue, StDataWait, StResp
    } state_e;

    state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         ready_prev_q;
    logic         cache_valid_q, cache_valid_d;
    logic [127:0] cached_key_q, cached_key_d;
    logic         cached_mode_q, cached_mode_d;
    logic [127:0] key_q, key_d, data_q, data_d, rsp_data_q, rsp_data_d;
    logic         sel_q, sel_d, rsp_err_q, rsp_err_d;
    logic         sm4_en_q, sm4_en_d, kexp_en_q, kexp_en_d, encdec_en_q, encdec_en_d;
    logic         key_valid_q, key_valid_d, valid_q, valid_d;
    logic         cmd_ready_q, rsp_valid_q, busy_q;
    logic         accept, hit, timeout;

    assign accept  = cmd_valid_i & cmd_ready_q;
    // A flush in the accept cycle must win over the cached entry.
    assign hit     = cache_valid_q & ~key_flush_i & (cmd_key_i == cached_key_q) &
                     (cmd_mode_i == cached_mode_q);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cache_valid_d = cache_valid_q;
        cached_key_d  = cached_key_q;
        cached_mode_d = cached_mode_q;
        key_d         = key_q;
        data_d        = data_q;
        sel_d         = sel_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        sm4_en_d      = sm4_en_q;
        kexp_en_d     = kexp_en_q;
        encdec_en_d   = encdec_en_q;
        key_valid_d   = 1'b0;
        valid_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    key_d  = cmd_key_i;
                    data_d = cmd_data_i;
                    sel_d  = cmd_mode_i;
                    if (hit) begin
                        state_d     = StIssue;
                        encdec_en_d = 1'b1;
                        valid_d     = 1'b1;
                    end else begin
                        state_d     = StKeyRst;
                        sm4_en_d    = 1'b0;
                        kexp_en_d   = 1'b0;
                        encdec_en_d = 1'b0;
                    end
                end
            end
            StKeyRst: begin
                state_d     = StKeyLoad;
                sm4_en_d    = 1'b1;
                kexp_en_d   = 1'b1;
                key_valid_d = 1'b1;
            end
            StKeyLoad: begin
                state_d = StKeyWait;
                cnt_d   = '0;
            end
            StKeyWait: begin
                cnt_d = cnt_q + 1'b1;
                if (core_key_ready_i) begin
                    cached_key_d  = key_q;
                    cached_mode_d = sel_q;
                    cache_valid_d = 1'b1;
                    state_d       = StIssue;
                    encdec_en_d   = 1'b1;
                    valid_d       = 1'b1;
                end else if (timeout) begin
                    state_d       = StResp;
                    rsp_err_d     = 1'b1;
                    rsp_data_d    = '0;
                    cache_valid_d = 1'b0;
                    sm4_en_d      = 1'b0;
                    kexp_en_d     = 1'b0;
                    encdec_en_d   = 1'b0;
                end
            end
            StIssue: begin
                state_d = StDataWait;
                cnt_d   = '0;
            end
            StDataWait: begin
                cnt_d = cnt_q + 1'b1;
                // Rising edge only: a level left over from the previous op is stale.
                if (core_ready_i && !ready_prev_q) begin
                    state_d    = StResp;
                    rsp_data_d = core_result_i;
                    rsp_err_d  = 1'b0;
                end else if (timeout) begin
                    state_d       = StResp;
                    rsp_err_d     = 1'b1;
                    rsp_data_d    = '0;
                    cache_valid_d = 1'b0;
                    sm4_en_d      = 1'b0;
                    kexp_en_d     = 1'b0;
                    encdec_en_d   = 1'b0;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (key_flush_i) cache_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ready_prev_q  <= 1'b0;
            cache_valid_q <= 1'b0;
            cached_key_q  <= '0;
            cached_mode_q <= 1'b0;
            key_q         <= '0;
            data_q        <= '0;
            sel_q         <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            sm4_en_q      <= 1'b0;
            kexp_en_q     <= 1'b0;
            encdec_en_q   <= 1'b0;
            key_valid_q   <= 1'b0;
            valid_q       <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ready_prev_q  <= core_ready_i;
            cache_valid_q <= cache_valid_d;
            cached_key_q  <= cached_key_d;
            cached_mode_q <= cached_mode_d;
            key_q         <= key_d;
            data_q        <= data_d;
            sel_q         <= sel_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            sm4_en_q      <= sm4_en_d;
            kexp_en_q     <= kexp_en_d;
            encdec_en_q   <= encdec_en_d;
            key_valid_q   <= key_valid_d;
            valid_q       <= valid_d;
            cmd_ready_q   <= (state_d == StIdle);
            rsp_valid_q   <= (state_d == StResp);
            busy_q        <= (state_d != StIdle);
        end
    end

    assign cmd_ready_o       = cmd_ready_q;
    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_data_o        = rsp_data_q;
    assign rsp_err_o         = rsp_err_q;
    assign core_sm4_enable_o = sm4_en_q;
    assign core_key_exp_en_o = kexp_en_q;
    assign core_key_valid_o  = key_valid_q;
    assign core_key_o        = key_q;
    assign core_encdec_en_o  = encdec_en_q;
    assign core_encdec_sel_o = sel_q;
    assign core_valid_o      = valid_q;
    assign core_data_o       = data_q;
    assign busy_o            = busy_q;

endmodule
